// File: rtl/ocx_tlx_rcv_cmd_queue.sv
// ocx_tlx_rcv_cmd_queue
// Buffers parsed VC1 commands from the TLX receive parser in a DEPTH-entry
// circular FIFO and presents them to the AFU with a valid/ready handshake.
// It returns one VC1 credit per dequeued command to the transmit side. After
// reset it advertises DEPTH initial credits once. A write into a full queue
// that is not draining in the same cycle is dropped and raises a sticky
// overflow flag.
module ocx_tlx_rcv_cmd_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INFO_W = 168
) (
  input  logic              tlx_clk,
  input  logic              reset,
  input  logic              fp_rcv_cmd_valid,
  input  logic [INFO_W-1:0] fp_rcv_cmd_info,
  output logic              tlx_afu_cmd_valid,
  output logic [INFO_W-1:0] tlx_afu_cmd_info,
  input  logic              afu_tlx_cmd_ready,
  input  logic              credit_hold,
  output logic              rcv_cmd_credit_v,
  output logic [3:0]        rcv_cmd_credit_cnt,
  output logic [3:0]        queue_count,
  output logic              overflow_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  logic [INFO_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, enq, deq;

  state_t           state_q;
  logic [4:0]       pending_q;
  logic             credit_v_q;
  logic [3:0]       credit_cnt_q;
  logic             issue;
  logic [3:0]       send_cnt;

  assign full  = (count_q == 4'(DEPTH));
  assign empty = (count_q == 4'd0);

  // Handshake decode and next-state for pointers, occupancy and overflow flag
  always_comb begin
    deq        = ~empty & afu_tlx_cmd_ready;
    enq        = fp_rcv_cmd_valid & (~full | deq);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fp_rcv_cmd_valid & full & ~deq);
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Queue control state
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Command storage; contents are don't-care while not covered by occupancy
  always_ff @(posedge tlx_clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= fp_rcv_cmd_info;
    end
  end

  // Credit issue decision for the RUN state
  always_comb begin
    issue    = (state_q == ST_RUN) && (pending_q != 5'd0) && !credit_hold;
    send_cnt = (pending_q > 5'd15) ? 4'd15 : pending_q[3:0];
  end

  // Credit FSM: one DEPTH-sized advertisement after reset, then per-dequeue returns.
  // A dequeue in the same cycle as an issue is folded into the new pending value.
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      pending_q    <= '0;
      credit_v_q   <= 1'b0;
      credit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          credit_v_q   <= 1'b1;
          credit_cnt_q <= 4'(DEPTH);
          pending_q    <= pending_q + {4'd0, deq};
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          credit_v_q   <= issue;
          credit_cnt_q <= issue ? send_cnt : 4'd0;
          pending_q    <= pending_q - (issue ? {1'b0, send_cnt} : 5'd0) + {4'd0, deq};
        end
        default: begin
          state_q      <= ST_INIT;
          credit_v_q   <= 1'b0;
          credit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign tlx_afu_cmd_valid  = ~empty;
  assign tlx_afu_cmd_info   = empty ? '0 : mem_q[rd_ptr_q];
  assign queue_count        = count_q;
  assign overflow_err       = overflow_q;
  assign rcv_cmd_credit_v   = credit_v_q;
  assign rcv_cmd_credit_cnt = credit_cnt_q;

endmodule

// File: tb/tb_ocx_tlx_rcv_cmd_queue.sv
// Testbench for ocx_tlx_rcv_cmd_queue: directed stimulus, a queue-based
// reference model checked every cycle, plus literal expectations per scenario.
module tb_ocx_tlx_rcv_cmd_queue;

  localparam int DEPTH  = 8;
  localparam int INFO_W = 168;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fpv = 1'b0;
  logic [INFO_W-1:0] fpi = '0;
  logic              rdy = 1'b0;
  logic              hold = 1'b0;
  logic              valid_o;
  logic [INFO_W-1:0] info_o;
  logic              cv_o;
  logic [3:0]        cc_o;
  logic [3:0]        count_o;
  logic              ov_o;

  always #5 clk = ~clk;

  ocx_tlx_rcv_cmd_queue #(
    .DEPTH  (DEPTH),
    .INFO_W (INFO_W)
  ) dut (
    .tlx_clk            (clk),
    .reset              (rst),
    .fp_rcv_cmd_valid   (fpv),
    .fp_rcv_cmd_info    (fpi),
    .tlx_afu_cmd_valid  (valid_o),
    .tlx_afu_cmd_info   (info_o),
    .afu_tlx_cmd_ready  (rdy),
    .credit_hold        (hold),
    .rcv_cmd_credit_v   (cv_o),
    .rcv_cmd_credit_cnt (cc_o),
    .queue_count        (count_o),
    .overflow_err       (ov_o)
  );

  int tests = 0;
  int fails = 0;
  int n_pulse = 0;
  int sum_cr = 0;

  // Reference model state (starts in reset state)
  logic [INFO_W-1:0] mq[$];
  int   m_pend = 0;
  bit   m_init = 1'b1;
  bit   m_cv = 1'b0;
  int   m_cc = 0;
  bit   m_ov = 1'b0;
  bit   m_deq, m_enq;

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_pend = 0;
        m_init = 1'b1;
        m_cv   = 1'b0;
        m_cc   = 0;
        m_ov   = 1'b0;
      end else begin
        m_deq = (mq.size() != 0) && rdy;
        m_enq = fpv && ((mq.size() < DEPTH) || m_deq);
        if (fpv && !m_enq) m_ov = 1'b1;
        if (m_deq) void'(mq.pop_front());
        if (m_enq) mq.push_back(fpi);
        if (m_init) begin
          m_cv = 1'b1;
          m_cc = DEPTH;
          m_init = 1'b0;
        end else if (m_pend != 0 && !hold) begin
          m_cv = 1'b1;
          m_cc = (m_pend > 15) ? 15 : m_pend;
          m_pend = m_pend - m_cc;
        end else begin
          m_cv = 1'b0;
          m_cc = 0;
        end
        if (m_deq) m_pend = m_pend + 1;
      end
    end
  end

  function automatic logic [INFO_W-1:0] info_of(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {21{b}};
  endfunction

  function automatic void check_w(input string name, input logic [INFO_W-1:0] act,
                                  input logic [INFO_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_n(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void compare_model();
    check_n("model_valid", int'(valid_o), int'(mq.size() != 0));
    check_w("model_info", info_o, (mq.size() != 0) ? mq[0] : '0);
    check_n("model_count", int'(count_o), mq.size());
    check_n("model_credit_v", int'(cv_o), int'(m_cv));
    check_n("model_credit_cnt", int'(cc_o), m_cc);
    check_n("model_overflow", int'(ov_o), int'(m_ov));
  endfunction

  // One clock of stimulus; outputs are compared at the falling edge
  task automatic step(input bit v, input logic [INFO_W-1:0] info, input bit r, input bit h);
    fpv  = v;
    fpi  = info;
    rdy  = r;
    hold = h;
    @(negedge clk);
    compare_model();
    if (cv_o) begin
      n_pulse++;
      sum_cr += int'(cc_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, h);
  endtask

  task automatic do_reset();
    fpv = 1'b0; rdy = 1'b0; hold = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset release, single initial advertisement
    repeat (3) @(posedge clk);
    #1;
    check_n("reset_valid", int'(valid_o), 0);
    check_n("reset_credit_v", int'(cv_o), 0);
    check_n("reset_count", int'(count_o), 0);
    rst = 1'b0;
    n_pulse = 0; sum_cr = 0;
    idle(6, 1'b0);
    check_n("init_pulses", n_pulse, 1);
    check_n("init_credits", sum_cr, 8);

    // Test 2: three commands, then drain in order
    for (int k = 1; k <= 3; k++) step(1'b1, info_of(k), 1'b0, 1'b0);
    check_n("t2_count", int'(count_o), 3);
    check_w("t2_head", info_o, info_of(1));
    n_pulse = 0; sum_cr = 0;
    for (int k = 1; k <= 3; k++) begin
      check_w("t2_order", info_o, info_of(k));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_n("t2_empty", int'(valid_o), 0);
    idle(4, 1'b0);
    check_n("t2_credits", sum_cr, 3);

    // Test 3: overflow on ninth write
    for (int k = 0; k < 8; k++) step(1'b1, info_of(10 + k), 1'b0, 1'b0);
    check_n("t3_full_no_ov", int'(ov_o), 0);
    step(1'b1, info_of(99), 1'b0, 1'b0);
    check_n("t3_overflow", int'(ov_o), 1);
    check_n("t3_count", int'(count_o), 8);
    check_w("t3_head", info_o, info_of(10));
    for (int k = 0; k < 8; k++) begin
      check_w("t3_drain", info_o, info_of(10 + k));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_n("t3_drained", int'(count_o), 0);
    check_n("t3_sticky", int'(ov_o), 1);
    idle(4, 1'b0);

    // Test 4: full queue with simultaneous write and read
    do_reset();
    idle(3, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, info_of(20 + k), 1'b0, 1'b0);
    step(1'b1, info_of(28), 1'b1, 1'b0);
    check_n("t4_count", int'(count_o), 8);
    check_n("t4_no_ov", int'(ov_o), 0);
    check_w("t4_head", info_o, info_of(21));
    for (int k = 1; k <= 8; k++) begin
      check_w("t4_drain", info_o, info_of(20 + k));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_n("t4_drained", int'(count_o), 0);
    idle(4, 1'b0);

    // Test 5: credit_hold defers returns, then one combined pulse
    n_pulse = 0; sum_cr = 0;
    for (int k = 0; k < 5; k++) step(1'b1, info_of(40 + k), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, 1'b1);
    idle(3, 1'b1);
    check_n("t5_held_pulses", n_pulse, 0);
    idle(4, 1'b0);
    check_n("t5_pulses", n_pulse, 1);
    check_n("t5_credits", sum_cr, 5);

    // Test 6: reset mid-operation with 4 queued and 2 pending
    for (int k = 0; k < 6; k++) step(1'b1, info_of(60 + k), 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, '0, 1'b1, 1'b1);
    check_n("t6_pre_count", int'(count_o), 4);
    #2;
    rst = 1'b1;
    #1;
    check_n("t6_async_valid", int'(valid_o), 0);
    check_n("t6_async_count", int'(count_o), 0);
    check_w("t6_async_info", info_o, '0);
    check_n("t6_async_cv", int'(cv_o), 0);
    hold = 1'b0; rdy = 1'b0; fpv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_pulse = 0; sum_cr = 0;
    idle(6, 1'b0);
    check_n("t6_pulses", n_pulse, 1);
    check_n("t6_credits", sum_cr, 8);
    check_n("t6_empty", int'(count_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
